// File: rtl/bcd_display_counter.sv
// bcd_display_counter: four-digit BCD up/down counter with a rate divider, clear, load and wrap pulse.
module bcd_display_counter #(
    parameter int TICK_DIV = 50000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        up_down,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic        wrap
);
    localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] div;
    logic [3:0]    dig [4];
    logic [3:0]    nxt [4];
    logic [3:0]    sat [4];
    logic          carry;
    logic          tick;

    assign tick = enable && div == LAST;

    // carry ends high only when every digit rolled over, i.e. the counter wraps
    always_comb begin
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sat[i] = load_value[4*i +: 4] > 4'd9 ? 4'd9 : load_value[4*i +: 4];
            nxt[i] = !carry ? dig[i] :
                     up_down ? (dig[i] == 4'd9 ? 4'd0 : dig[i] + 4'd1) :
                               (dig[i] == 4'd0 ? 4'd9 : dig[i] - 4'd1);
            carry = carry && (up_down ? dig[i] == 4'd9 : dig[i] == 4'd0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            div  <= '0;
            wrap <= 1'b0;
            dig  <= '{default: 4'd0};
        end else if (load) begin
            div  <= '0;
            wrap <= 1'b0;
            dig  <= sat;
        end else begin
            wrap <= tick && carry;
            if (enable)
                div <= tick ? '0 : div + DW'(1);
            if (tick)
                dig <= nxt;
        end
    end

    assign digit0 = dig[0];
    assign digit1 = dig[1];
    assign digit2 = dig[2];
    assign digit3 = dig[3];
endmodule

// File: tb/tb_bcd_display_counter.sv
// tb_bcd_display_counter: table vectors, corner sequences and a decimal reference model for two divider settings.
module tb_bcd_display_counter;
    logic        clock = 1'b0;
    logic        reset, enable, clear, load, up_down;
    logic [15:0] load_value;
    logic [3:0]  a0, a1, a2, a3, b0, b1, b2, b3;
    logic        a_w, b_w;
    logic [15:0] a_q, b_q;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        bit          r, e, c, l, ud;
        logic [15:0] lv;
        logic [15:0] q;
        bit          w;
    } vec_t;
    vec_t tbl [18];

    int mv [2];
    int md [2];
    bit mw [2];
    int nd [2] = '{4, 1};

    always #5 clock = ~clock;

    bcd_display_counter #(.TICK_DIV(4)) u4 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value), .up_down(up_down),
        .digit0(a0), .digit1(a1), .digit2(a2), .digit3(a3), .wrap(a_w));

    bcd_display_counter #(.TICK_DIV(1)) u1 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value), .up_down(up_down),
        .digit0(b0), .digit1(b1), .digit2(b2), .digit3(b3), .wrap(b_w));

    assign a_q = {a3, a2, a1, a0};
    assign b_q = {b3, b2, b1, b0};

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int satv(input logic [15:0] x);
        int s = 0;
        int m = 1;
        for (int i = 0; i < 4; i++) begin
            s += (x[4*i +: 4] > 4'd9 ? 9 : int'(x[4*i +: 4])) * m;
            m *= 10;
        end
        return s;
    endfunction

    // reference: the count as a decimal integer modulo 10000, divider as a cycle counter
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (reset || clear) begin
                mv[k] = 0; md[k] = 0; mw[k] = 0;
            end else if (load) begin
                mv[k] = satv(load_value); md[k] = 0; mw[k] = 0;
            end else begin
                mw[k] = 0;
                if (enable) begin
                    if (md[k] == nd[k] - 1) begin
                        md[k] = 0;
                        mw[k] = up_down ? mv[k] == 9999 : mv[k] == 0;
                        mv[k] = up_down ? (mv[k] + 1) % 10000 : (mv[k] + 9999) % 10000;
                    end else
                        md[k]++;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, e, c, l, ud, input logic [15:0] lv);
        reset = r; enable = e; clear = c; load = l; up_down = ud; load_value = lv;
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
        chk("model4_q", int'(a_q), int'(bcd(mv[0])));
        chk("model4_wrap", int'(a_w), int'(mw[0]));
        chk("model1_q", int'(b_q), int'(bcd(mv[1])));
        chk("model1_wrap", int'(b_w), int'(mw[1]));
    endtask

    initial begin
        drive(1, 0, 0, 0, 1, 16'h0);
        tbl[0]  = '{1, 0, 0, 0, 1, 16'h0000, 16'h0000, 0};
        tbl[1]  = '{0, 0, 0, 1, 1, 16'h9999, 16'h9999, 0};
        tbl[2]  = '{0, 1, 0, 0, 1, 16'h0000, 16'h0000, 1};
        tbl[3]  = '{0, 1, 0, 0, 1, 16'h0000, 16'h0001, 0};
        tbl[4]  = '{0, 1, 0, 1, 1, 16'h0000, 16'h0000, 0};
        tbl[5]  = '{0, 1, 0, 0, 0, 16'h0000, 16'h9999, 1};
        tbl[6]  = '{0, 0, 0, 0, 0, 16'h0000, 16'h9999, 0};
        tbl[7]  = '{0, 0, 0, 1, 1, 16'h0999, 16'h0999, 0};
        tbl[8]  = '{0, 1, 0, 0, 1, 16'h0000, 16'h1000, 0};
        tbl[9]  = '{0, 0, 0, 1, 0, 16'h1000, 16'h1000, 0};
        tbl[10] = '{0, 1, 0, 0, 0, 16'h0000, 16'h0999, 0};
        tbl[11] = '{0, 0, 0, 1, 1, 16'hF3A7, 16'h9397, 0};
        tbl[12] = '{0, 1, 1, 1, 1, 16'h5555, 16'h0000, 0};
        tbl[13] = '{1, 1, 0, 1, 1, 16'h1234, 16'h0000, 0};
        tbl[14] = '{0, 1, 0, 1, 1, 16'h1234, 16'h1234, 0};
        tbl[15] = '{0, 0, 1, 0, 1, 16'h0000, 16'h0000, 0};
        tbl[16] = '{0, 1, 0, 0, 0, 16'h0000, 16'h9999, 1};
        tbl[17] = '{0, 0, 0, 0, 0, 16'h0000, 16'h9999, 0};
        @(negedge clock);
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].l, tbl[i].ud, tbl[i].lv);
            cyc();
            chk($sformatf("vec%0d_q", i), int'(b_q), int'(tbl[i].q));
            chk($sformatf("vec%0d_wrap", i), int'(b_w), int'(tbl[i].w));
        end

        drive(1, 0, 0, 0, 1, 16'h0);
        cyc();
        chk("reset_q", int'(a_q), 0);
        drive(0, 1, 0, 0, 1, 16'h0);
        for (int k = 1; k <= 40; k++) begin
            cyc();
            chk("basic_q", int'(a_q), int'(bcd(k / 4)));
            chk("basic_wrap", int'(a_w), 0);
        end
        chk("basic_end", int'(a_q), 16'h0010);

        drive(1, 0, 0, 0, 1, 16'h0);
        cyc();
        drive(0, 1, 0, 0, 1, 16'h0);
        repeat (2) cyc();
        drive(0, 0, 0, 0, 1, 16'h0);
        repeat (10) cyc();
        chk("freeze_hold", int'(a_q), 16'h0000);
        drive(0, 1, 0, 0, 1, 16'h0);
        cyc();
        chk("freeze_pre", int'(a_q), 16'h0000);
        cyc();
        chk("freeze_step", int'(a_q), 16'h0001);

        repeat (3) cyc();
        drive(1, 1, 0, 0, 1, 16'h0);
        cyc();
        chk("midreset_q", int'(a_q), 16'h0000);
        drive(0, 1, 0, 0, 1, 16'h0);
        repeat (3) cyc();
        chk("midreset_hold", int'(a_q), 16'h0000);
        cyc();
        chk("midreset_step", int'(a_q), 16'h0001);

        repeat (3) cyc();
        drive(0, 1, 1, 1, 1, 16'h4321);
        cyc();
        chk("clrld_tick_q", int'(a_q), 16'h0000);
        drive(0, 1, 0, 0, 1, 16'h0);
        repeat (3) cyc();
        chk("clrld_div0", int'(a_q), 16'h0000);
        cyc();
        chk("clrld_step", int'(a_q), 16'h0001);

        repeat (3) cyc();
        drive(0, 1, 0, 1, 1, 16'h0042);
        cyc();
        chk("ld_tick_q", int'(a_q), 16'h0042);
        drive(0, 1, 0, 0, 1, 16'h0);
        repeat (3) cyc();
        chk("ld_div0", int'(a_q), 16'h0042);
        cyc();
        chk("ld_step", int'(a_q), 16'h0043);

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(99) < 2, $urandom_range(99) < 80, $urandom_range(99) < 3,
                  $urandom_range(99) < 4, $urandom_range(99) < 60, 16'($urandom));
            if ($urandom_range(99) < 5) load_value = {$urandom_range(1) ? 4'h9 : 4'h0, 12'h999};
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_display_counter.md
BCD_DISPLAY_COUNTER -- requirements
Module: bcd_display_counter

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000, meaning clock cycles per count step (legal range 1 to 2^26).
REQ-002 The block SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port enable  input  1  1 = run divider and count; 0 = freeze divider and digits.
REQ-005 The block SHALL have port clear  input  1  synchronous zero of digits and divider.
REQ-006 The block SHALL have port load  input  1  synchronous load of load_value.
REQ-007 The block SHALL have port load_value  input  16  four BCD nibbles; [3:0] is the least-significant digit.
REQ-008 The block SHALL have port up_down  input  1  1 = count up, 0 = count down.
REQ-009 The block SHALL have ports digit0, digit1, digit2, digit3  output  4 each  registered BCD digits; digit0 is the least significant; each drives one seven-segment hex decoder.
REQ-010 The block SHALL have port wrap  output  1  registered one-cycle pulse on 9999->0000 (up) or 0000->9999 (down).

Function
REQ-011 The rate divider SHALL count 0 to TICK_DIV-1 while enable=1 and hold its value while enable=0.
REQ-012 Internal tick SHALL be 1 in exactly those cycles where enable=1 and divider = TICK_DIV-1; the divider SHALL return to 0 on the following edge.
REQ-013 TICK_DIV=1 SHALL produce a tick in every cycle with enable=1.
REQ-014 On each tick edge, digits SHALL step by one in BCD, and the new value SHALL be visible in the next cycle (latency 1 clock from tick).
REQ-015 Counting up, a digit at 9 SHALL become 0 and carry into the next digit; a digit SHALL never hold A-F as the result of counting.
REQ-016 Counting down, a digit at 0 SHALL become 9 and borrow from the next digit.
REQ-017 Up at 9999 SHALL give 0000 with wrap=1; down at 0000 SHALL give 9999 with wrap=1; wrap SHALL be 1 in the same cycle the wrapped value first appears, and 0 otherwise.
REQ-018 A change of up_down SHALL take effect at the next tick only; the divider SHALL NOT be disturbed.
REQ-019 Priority per edge SHALL be reset > clear > load > tick.
REQ-020 clear=1 SHALL set all digits and the divider to 0 and wrap to 0, regardless of enable.
REQ-021 load=1 (clear=0) SHALL copy load_value into the digits, zero the divider and set wrap to 0, regardless of enable.
REQ-022 Any load_value nibble above 9 SHALL be stored as 9.
REQ-023 A tick coinciding with clear or load SHALL be discarded; no count step SHALL occur for it.
REQ-024 With enable=0 and no clear or load, all outputs SHALL hold.

Reset
REQ-025 reset=1 at an edge SHALL set digit0..digit3 = 0, wrap = 0 and divider = 0, overriding clear, load and enable.
REQ-026 Reset asserted mid-count SHALL abandon the partial divider period; counting SHALL restart from a full TICK_DIV period after reset deasserts.
REQ-027 Outputs SHALL be undefined only before the first reset edge; no asynchronous path to any register SHALL exist.

Verification
REQ-028 Basic count: TICK_DIV=4, reset, enable=1, up_down=1 for 40 cycles -> digits step every 4 cycles, reaching 0010 after cycle 40; wrap stays 0.
REQ-029 Wrap up and down: load 9999, TICK_DIV=1, up -> next step gives 0000 with wrap=1 for exactly one cycle; load 0000, down -> 9999 with wrap=1.
REQ-030 Cascade: load 0999, up, one tick -> 1000; load 1000, down, one tick -> 0999.
REQ-031 Load saturation: load_value=16'hF3A7 -> digits 9,3,9,7 (digit3..digit0).
REQ-032 Priority and collisions: clear and load asserted together on a tick edge -> 0000, divider 0, no step; reset together with load -> 0000.
REQ-033 Freeze: TICK_DIV=4, enable dropped with divider at 2 for 10 cycles, then raised -> next step exactly 2 enabled cycles later (hold, not restart).
